// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester-channel and memory-port bundle for mem_bus_arbiter
interface mem_bus_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
);
    localparam int MW = DW / 8;

    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_we;
    logic [NUM_CH*AW-1:0] ch_addr;
    logic [NUM_CH*DW-1:0] ch_wdata;
    logic [NUM_CH*MW-1:0] ch_mask;
    logic [NUM_CH*DW-1:0] ch_rdata;
    logic [NUM_CH-1:0]    ch_ready;
    logic [NUM_CH-1:0]    ch_err;

    logic                 mem_req;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [MW-1:0]        mem_mask;
    logic [DW-1:0]        mem_rdata;
    logic                 mem_ready;

    modport master (
        input  ch_req, ch_we, ch_addr, ch_wdata, ch_mask, mem_rdata, mem_ready,
        output ch_rdata, ch_ready, ch_err, mem_req, mem_we, mem_addr, mem_wdata, mem_mask
    );

    modport slave (
        output ch_req, ch_we, ch_addr, ch_wdata, ch_mask, mem_rdata, mem_ready,
        input  ch_rdata, ch_ready, ch_err, mem_req, mem_we, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter of NUM_CH requesters onto one memory port
// Optional address window check compiled in with MEM_RANGE_CHK_EN.
module mem_bus_arbiter #(
    parameter int            NUM_CH     = 2,
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter logic [AW-1:0] ADDR_STRIP = 32'h8000_0000,
    parameter logic [AW-1:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [AW-1:0] MEM_SIZE   = 32'h0800_0000
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);
    localparam int            MW  = DW / 8;
    localparam int            IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IW:0]   NCH = (IW+1)'(NUM_CH);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nxt;

    logic [AW-1:0] addr_a  [NUM_CH];
    logic [DW-1:0] wdata_a [NUM_CH];
    logic [MW-1:0] mask_a  [NUM_CH];
    logic [DW-1:0] rdata_q [NUM_CH];

    logic [IW-1:0] rr_ptr, gnt_id, pick_id;
    logic [IW:0]   scan;
    logic          pick_vld, pick_bad, err_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [MW-1:0] mask_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign addr_a[i]                  = bus.ch_addr[i*AW +: AW];
        assign wdata_a[i]                 = bus.ch_wdata[i*DW +: DW];
        assign mask_a[i]                  = bus.ch_mask[i*MW +: MW];
        assign bus.ch_rdata[i*DW +: DW]   = rdata_q[i];
        assign bus.ch_ready[i]            = (state == RESP) && (gnt_id == IW'(i));
        assign bus.ch_err[i]              = (state == RESP) && (gnt_id == IW'(i)) && err_q;
    end

    assign bus.mem_req   = (state == ISSUE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_mask  = mask_q;

    // Scan starts one past the last winner so every requester is served within NUM_CH grants
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        scan     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            scan = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan >= NCH) begin
                scan = scan - NCH;
            end
            if (!pick_vld && bus.ch_req[scan[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = scan[IW-1:0];
            end
        end
    end

`ifdef MEM_RANGE_CHK_EN
    // One extra bit keeps MEM_BASE+MEM_SIZE from wrapping at the top of the address space
    logic [AW:0] pick_addr_x;
    assign pick_addr_x = {1'b0, addr_a[pick_id]};
    assign pick_bad    = (pick_addr_x < {1'b0, MEM_BASE}) ||
                         (pick_addr_x >= ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));
`else
    logic unused_cfg;
    assign unused_cfg = ^{MEM_BASE, MEM_SIZE};
    assign pick_bad   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = pick_bad ? RESP : ISSUE;
            ISSUE:   if (bus.mem_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= IW'(NUM_CH - 1);
            gnt_id  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_id  <= pick_id;
                        rr_ptr  <= pick_id;
                        err_q   <= pick_bad;
                        we_q    <= bus.ch_we[pick_id];
                        addr_q  <= addr_a[pick_id] & ~ADDR_STRIP;
                        wdata_q <= wdata_a[pick_id];
                        mask_q  <= mask_a[pick_id];
                        if (pick_bad && !bus.ch_we[pick_id]) begin
                            rdata_q[pick_id] <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready && !we_q) begin
                        rdata_q[gnt_id] <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    localparam int          NUM_CH = 3;
    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam int          MW     = DW / 8;
    localparam logic [31:0] STRIP  = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW)) bus ();

    mem_bus_arbiter #(
        .NUM_CH(NUM_CH), .AW(AW), .DW(DW), .ADDR_STRIP(STRIP),
        .MEM_BASE(32'h8000_0000), .MEM_SIZE(32'h0800_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int          mem_lat = 0;
    bit          spur    = 1'b0;
    int          acc_cnt = 0;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_mask;
    logic [31:0] mem_store [logic [31:0]];

    logic [NUM_CH-1:0] pend;
    logic              rq_we    [NUM_CH];
    logic [31:0]       rq_addr  [NUM_CH];
    logic [31:0]       rq_wdata [NUM_CH];
    logic [3:0]        rq_mask  [NUM_CH];
    logic [31:0]       exp_rdata[NUM_CH];
    int                last_g;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [NUM_CH*DW-1:0] exp_vec();
        logic [NUM_CH*DW-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i*DW +: DW] = exp_rdata[i];
        return v;
    endfunction

    function automatic int predict();
        for (int k = 1; k <= NUM_CH; k++) begin
            if (pend[(last_g + k) % NUM_CH]) return (last_g + k) % NUM_CH;
        end
        return 0;
    endfunction

    // Memory slave: answers after mem_lat wait cycles, junk on mem_rdata otherwise
    initial begin
        logic [31:0] cur;
        int wait_cnt;
        wait_cnt      = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req === 1'b1) begin
                if (wait_cnt >= mem_lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_rd(bus.mem_addr);
                    last_we    = bus.mem_we;
                    last_addr  = bus.mem_addr;
                    last_wdata = bus.mem_wdata;
                    last_mask  = bus.mem_mask;
                    acc_cnt++;
                    if (bus.mem_we) begin
                        cur = mem_rd(bus.mem_addr);
                        for (int b = 0; b < MW; b++)
                            if (bus.mem_mask[b]) cur[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                        mem_store[bus.mem_addr] = cur;
                    end
                    wait_cnt = 0;
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ready = spur;
                bus.mem_rdata = $urandom;
                wait_cnt      = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int c, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        pend[c] = 1'b1;
        rq_we[c] = we; rq_addr[c] = a; rq_wdata[c] = d; rq_mask[c] = m;
        bus.ch_req[c] = 1'b1;
        bus.ch_we[c]  = we;
        bus.ch_addr[c*AW +: AW]  = a;
        bus.ch_wdata[c*DW +: DW] = d;
        bus.ch_mask[c*MW +: MW]  = m;
    endtask

    task automatic retire(input int c);
        pend[c]       = 1'b0;
        bus.ch_req[c] = 1'b0;
        bus.ch_we[c]  = 1'b0;
    endtask

    task automatic rand_issue(input int c);
        logic [31:0] a;
        a = 32'h8000_0000 | (32'($urandom_range(0, 1)) << 26) | (32'($urandom_range(0, 15)) << 2);
        issue(c, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) retire(c);
        repeat (n) @(negedge clk);
        rst = 1'b1;
        last_g = NUM_CH - 1;
        for (int i = 0; i < NUM_CH; i++) exp_rdata[i] = '0;
    endtask

    // Expect channel g to complete exactly gap cycles after the current negedge
    task automatic expect_completion(input int g, input int gap, input string tag);
        logic [NUM_CH-1:0] oh;
        int acc0;
        oh = '0;
        oh[g] = 1'b1;
        acc0 = acc_cnt;
        for (int k = 1; k < gap; k++) begin
            @(negedge clk);
            chk({tag, "_early"}, bus.ch_ready, '0);
        end
        @(negedge clk);
        chk({tag, "_ready"}, bus.ch_ready, oh);
        chk({tag, "_err"}, bus.ch_err, '0);
        chk({tag, "_memreq"}, bus.mem_req, 1'b0);
        if (!rq_we[g]) exp_rdata[g] = mem_rd(rq_addr[g] & ~STRIP);
        chk({tag, "_rdata"}, bus.ch_rdata, exp_vec());
        chk({tag, "_acc"}, acc_cnt - acc0, 1);
        chk({tag, "_addr"}, last_addr, rq_addr[g] & ~STRIP);
        chk({tag, "_we"}, last_we, rq_we[g]);
        if (rq_we[g]) begin
            chk({tag, "_wdata"}, last_wdata, rq_wdata[g]);
            chk({tag, "_mask"}, last_mask, rq_mask[g]);
        end
        last_g = g;
    endtask

    initial begin
        int g, gap, acc0;
        int ord[4];
        bus.ch_req = '0; bus.ch_we = '0; bus.ch_addr = '0; bus.ch_wdata = '0; bus.ch_mask = '0;
        pend = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rq_we[i] = 1'b0; rq_addr[i] = '0; rq_wdata[i] = '0; rq_mask[i] = '0; exp_rdata[i] = '0;
        end
        last_g = NUM_CH - 1;

        // Reset: all outputs zero, then idle with stray mem_ready
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, '0);
        chk("rst_mem_wdata", bus.mem_wdata, '0);
        chk("rst_mem_mask", bus.mem_mask, '0);
        chk("rst_ch_ready", bus.ch_ready, '0);
        chk("rst_ch_err", bus.ch_err, '0);
        chk("rst_ch_rdata", bus.ch_rdata, '0);
        rst = 1'b1;
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_mem_req", bus.mem_req, 1'b0);
            chk("idle_ready", bus.ch_ready, '0);
        end
        spur = 1'b0;
        @(negedge clk);

        // Single read, zero wait states
        mem_store[32'h0000_0010] = 32'hA5A5_0001;
        mem_lat = 0;
        issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
        @(negedge clk);
        chk("t2_mem_req", bus.mem_req, 1'b1);
        chk("t2_mem_addr", bus.mem_addr, 32'h0000_0010);
        chk("t2_mem_we", bus.mem_we, 1'b0);
        chk("t2_no_ready", bus.ch_ready, '0);
        @(negedge clk);
        chk("t2_ready", bus.ch_ready, 3'b001);
        chk("t2_rdata0", bus.ch_rdata[31:0], 32'hA5A5_0001);
        chk("t2_mem_req_off", bus.mem_req, 1'b0);
        exp_rdata[0] = 32'hA5A5_0001;
        last_g = 0;
        retire(0);
        @(negedge clk);
        chk("t2_pulse", bus.ch_ready, '0);
        chk("t2_rdata_all", bus.ch_rdata, exp_vec());

        // Contention from reset: grants alternate 0,1,0,1
        apply_reset(2);
        mem_lat = 1;
        issue(0, 1'b0, 32'h8000_0040, 32'h0, 4'hF);
        issue(1, 1'b0, 32'h8000_0080, 32'h0, 4'hF);
        ord = '{0, 1, 0, 1};
        for (int a = 0; a < 4; a++) expect_completion(ord[a], (a == 0) ? 3 : 4, "t3");
        retire(0);
        retire(1);

        // Write with three wait states
        @(negedge clk);
        mem_lat = 3;
        issue(1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_mem_req", bus.mem_req, 1'b1);
            chk("t4_mem_we", bus.mem_we, 1'b1);
            chk("t4_mem_addr", bus.mem_addr, 32'h0000_0100);
            chk("t4_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("t4_mem_mask", bus.mem_mask, 4'b0011);
            chk("t4_no_ready", bus.ch_ready, '0);
        end
        @(negedge clk);
        chk("t4_ready", bus.ch_ready, 3'b010);
        chk("t4_mem_req_off", bus.mem_req, 1'b0);
        chk("t4_rdata_kept", bus.ch_rdata, exp_vec());
        last_g = 1;
        retire(1);
        mem_lat = 0;
        issue(1, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
        expect_completion(1, 3, "t4_rb");
        chk("t4_merge", bus.ch_rdata[63:32], 32'hC0DE_BEEF);
        retire(1);

        // Request dropped while the access is in flight
        @(negedge clk);
        mem_lat = 2;
        issue(2, 1'b0, 32'h8000_0200, 32'h0, 4'hF);
        @(negedge clk);
        bus.ch_req[2] = 1'b0;
        expect_completion(2, 3, "t_drop");
        retire(2);

        // Reset in the middle of an access
        @(negedge clk);
        mem_lat = 5;
        issue(0, 1'b0, 32'h8000_0300, 32'h0, 4'hF);
        @(negedge clk);
        chk("t5_mem_req_on", bus.mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_mem_req_abort", bus.mem_req, 1'b0);
        chk("t5_ready_abort", bus.ch_ready, '0);
        chk("t5_rdata_clr", bus.ch_rdata, '0);
        apply_reset(2);
        repeat (5) begin
            @(negedge clk);
            chk("t5_quiet_ready", bus.ch_ready, '0);
            chk("t5_quiet_req", bus.mem_req, 1'b0);
        end
        mem_lat = 0;
        issue(1, 1'b0, 32'h8000_0304, 32'h0, 4'hF);
        issue(0, 1'b0, 32'h8000_0300, 32'h0, 4'hF);
        expect_completion(0, 2, "t5_a");
        expect_completion(1, 3, "t5_b");
        retire(0);
        retire(1);

`ifdef MEM_RANGE_CHK_EN
        // Out-of-window addresses complete at once with ch_err and no memory access
        @(negedge clk);
        acc0 = acc_cnt;
        issue(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        @(negedge clk);
        chk("t6_ready", bus.ch_ready, 3'b001);
        chk("t6_err", bus.ch_err, 3'b001);
        chk("t6_mem_req", bus.mem_req, 1'b0);
        chk("t6_rdata0", bus.ch_rdata[31:0], 32'h0);
        exp_rdata[0] = '0;
        last_g = 0;
        retire(0);
        @(negedge clk);
        chk("t6_no_access", acc_cnt - acc0, 0);
        chk("t6_err_clr", bus.ch_err, '0);
        issue(0, 1'b0, 32'h8800_0000, 32'h0, 4'hF);
        @(negedge clk);
        chk("t6_top_err", bus.ch_err, 3'b001);
        retire(0);
        @(negedge clk);
        issue(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF);
        @(negedge clk);
        chk("t6_nowrap_err", bus.ch_err, 3'b001);
        retire(0);
        @(negedge clk);
        issue(0, 1'b0, 32'h87FF_FFFC, 32'h0, 4'hF);
        expect_completion(0, 2, "t6_legal");
        retire(0);
`endif

        // Randomized traffic against the rotation/memory model
        @(negedge clk);
        mem_lat = $urandom_range(0, 3);
        rand_issue($urandom_range(0, NUM_CH - 1));
        for (int c = 0; c < NUM_CH; c++)
            if (!pend[c] && $urandom_range(0, 1) == 1) rand_issue(c);
        gap = 2 + mem_lat;
        repeat (60) begin
            g = predict();
            expect_completion(g, gap, "rand");
            retire(g);
            for (int c = 0; c < NUM_CH; c++)
                if (!pend[c] && $urandom_range(0, 2) != 0) rand_issue(c);
            if (pend == '0) rand_issue($urandom_range(0, NUM_CH - 1));
            mem_lat = $urandom_range(0, 3);
            gap = 3 + mem_lat;
        end
        for (int c = 0; c < NUM_CH; c++) retire(c);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
